// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter
//   Two-requester write arbiter in front of a bank of NREG registers.
//   A granted request becomes one WRITE cycle on the bank side: a one-hot
//   register select, a shared write enable and shared write data. Simultaneous
//   requests are resolved round-robin. Requesters hold req/addr/data until they
//   see their ack pulse. An address outside the bank is acknowledged with err
//   and does not touch the bank.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-low
//   req0/1         write request, held until the matching ack
//   addr0/1        target register index (AW bits)
//   data0/1        write data (DW bits)
//   ack0/1         1-cycle pulse, transaction committed
//   chosen         one-hot register select into the bank (zero when idle)
//   w_en           write enable into the bank
//   w_data         write data into the bank
//   busy           high during a WRITE cycle
//   err            1-cycle pulse, acked transaction had addr >= NREG
module regbank_write_arbiter #(
   parameter int NREG = 6,
   parameter int AW   = 3,
   parameter int DW   = 13
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0,
   input  logic [AW-1:0]   addr0,
   input  logic [DW-1:0]   data0,
   output logic            ack0,
   input  logic            req1,
   input  logic [AW-1:0]   addr1,
   input  logic [DW-1:0]   data1,
   output logic            ack1,
   output logic [NREG-1:0] chosen,
   output logic            w_en,
   output logic [DW-1:0]   w_data,
   output logic            busy,
   output logic            err
);

   typedef enum logic {IDLE, WRITE} state_t;

   // NREG may equal 2**AW, so the range limit needs one extra bit.
   localparam logic [AW:0] NREG_LIMIT = (AW + 1)'(NREG);

   state_t          state_reg, state_next;
   logic            winner_reg, winner_next;
   logic            rr_reg, rr_next;

   logic            grant_valid;
   logic [AW-1:0]   grant_addr;
   logic [DW-1:0]   grant_data;
   logic            grant_in_range;
   logic [NREG-1:0] grant_onehot;

   logic [NREG-1:0] chosen_reg;
   logic            w_en_reg;
   logic [DW-1:0]   w_data_reg;
   logic            ack0_reg, ack1_reg;
   logic            busy_reg;
   logic            err_reg;

   // Decide what the next cycle does. grant_valid means the next cycle is a
   // WRITE for requester winner_next; its outputs are registered below.
   always_comb begin
      state_next  = state_reg;
      winner_next = winner_reg;
      rr_next     = rr_reg;
      grant_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               grant_valid = 1'b1;
               state_next  = WRITE;
               winner_next = (req0 && req1) ? rr_reg : req1;
            end
         end
         WRITE: begin
            rr_next = ~winner_reg;
            // Only the loser may follow directly; the requester just acked
            // is still showing its old request on this edge.
            if (winner_reg ? req0 : req1) begin
               grant_valid = 1'b1;
               winner_next = ~winner_reg;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign grant_addr     = winner_next ? addr1 : addr0;
   assign grant_data     = winner_next ? data1 : data0;
   assign grant_in_range = ({1'b0, grant_addr} < NREG_LIMIT);

   // Out-of-range addresses match no slice, so the select stays zero for them.
   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_sel
         assign grant_onehot[gi] = (grant_addr == AW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         winner_reg <= 1'b0;
         rr_reg     <= 1'b0;
         chosen_reg <= '0;
         w_en_reg   <= 1'b0;
         w_data_reg <= '0;
         ack0_reg   <= 1'b0;
         ack1_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         winner_reg <= winner_next;
         rr_reg     <= rr_next;
         chosen_reg <= grant_valid ? grant_onehot : '0;
         w_en_reg   <= grant_valid & grant_in_range;
         ack0_reg   <= grant_valid & ~winner_next;
         ack1_reg   <= grant_valid & winner_next;
         busy_reg   <= grant_valid;
         err_reg    <= grant_valid & ~grant_in_range;
         // Data is latched at grant and held between writes.
         if (grant_valid) begin
            w_data_reg <= grant_data;
         end
      end
   end

   assign chosen = chosen_reg;
   assign w_en   = w_en_reg;
   assign w_data = w_data_reg;
   assign ack0   = ack0_reg;
   assign ack1   = ack1_reg;
   assign busy   = busy_reg;
   assign err    = err_reg;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed testbench for regbank_write_arbiter. Includes a behavioural model
// of the register bank so that writes can be observed afterwards.
module tb_regbank_write_arbiter;

   localparam int NREG = 6;
   localparam int AW   = 3;
   localparam int DW   = 13;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            req0, req1;
   logic [AW-1:0]   addr0, addr1;
   logic [DW-1:0]   data0, data1;
   logic            ack0, ack1;
   logic [NREG-1:0] chosen;
   logic            w_en;
   logic [DW-1:0]   w_data;
   logic            busy;
   logic            err;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] bank [NREG] = '{default: '0};
   logic [DW-1:0] snap [NREG];
   int            wr4_cnt = 0;

   regbank_write_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .addr0  (addr0),
      .data0  (data0),
      .ack0   (ack0),
      .req1   (req1),
      .addr1  (addr1),
      .data1  (data1),
      .ack1   (ack1),
      .chosen (chosen),
      .w_en   (w_en),
      .w_data (w_data),
      .busy   (busy),
      .err    (err)
   );

   always #5 clk = ~clk;

   // Register bank: each slice captures w_data when selected and enabled.
   always @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (w_en && chosen[i]) bank[i] <= w_data;
      end
      if (w_en && chosen[4]) wr4_cnt <= wr4_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Mutual exclusion on every cycle out of reset.
   always @(negedge clk) begin
      if (rst) begin
         chk("mutex", {30'd0, ack0 & ack1, ($countones(chosen) > 1)}, 32'd0);
      end
   end

   logic [7:0] e_ack0;
   logic [7:0] e_ack1;
   int         n;
   int         raise_c;
   int         wr4_base;
   logic [NREG-1:0] exp_sel;

   initial begin
      // 1. Reset with a request already pending.
      rst = 1'b0;
      req0 = 1'b1; addr0 = 3'd0; data0 = 13'h0123;
      req1 = 1'b0; addr1 = 3'd0; data1 = 13'h0000;
      tick(); tick();
      chk("rst_chosen", {26'd0, chosen}, 32'd0);
      chk("rst_w_en",   {31'd0, w_en},   32'd0);
      chk("rst_ack0",   {31'd0, ack0},   32'd0);
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_err",    {31'd0, err},    32'd0);
      $display("txn reset: held req0 blocked");
      rst = 1'b1;
      tick();
      chk("rel_ack0",   {31'd0, ack0},   32'd1);
      chk("rel_w_en",   {31'd0, w_en},   32'd1);
      chk("rel_chosen", {26'd0, chosen}, 32'h01);
      chk("rel_w_data", {19'd0, w_data}, 32'h0123);
      $display("txn release: req0 addr=0 acked");
      req0 = 1'b0;
      tick();
      chk("idle_ack0",  {31'd0, ack0},   32'd0);
      chk("idle_busy",  {31'd0, busy},   32'd0);

      // 2. Single write to reg3.
      req0 = 1'b1; addr0 = 3'd3; data0 = 13'h1ABC;
      tick();
      chk("sw_chosen", {26'd0, chosen}, 32'h08);
      chk("sw_w_data", {19'd0, w_data}, 32'h1ABC);
      chk("sw_w_en",   {31'd0, w_en},   32'd1);
      chk("sw_ack0",   {31'd0, ack0},   32'd1);
      chk("sw_busy",   {31'd0, busy},   32'd1);
      req0 = 1'b0;
      tick();
      chk("sw_bank3",  {19'd0, bank[3]}, 32'h1ABC);
      $display("txn single: req0 addr=3 data=1abc");

      // 3. Contention from reset: strict alternation starting with req0.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      req0 = 1'b1; addr0 = 3'd1; data0 = 13'h0011;
      req1 = 1'b1; addr1 = 3'd2; data1 = 13'h0022;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk("ct_ack0",   {31'd0, ack0}, (c % 2 == 0) ? 32'd1 : 32'd0);
         chk("ct_ack1",   {31'd0, ack1}, (c % 2 == 1) ? 32'd1 : 32'd0);
         chk("ct_chosen", {26'd0, chosen}, (c % 2 == 0) ? 32'h02 : 32'h04);
         chk("ct_w_data", {19'd0, w_data}, (c % 2 == 0) ? 32'h0011 : 32'h0022);
         $display("txn contend %0d: ack0=%0d ack1=%0d chosen=%b", c, ack0, ack1, chosen);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      chk("ct_idle_busy", {31'd0, busy}, 32'd0);

      // 4. Out-of-range address.
      for (int i = 0; i < NREG; i++) snap[i] = bank[i];
      req1 = 1'b1; addr1 = 3'd7; data1 = 13'h0555;
      tick();
      chk("oor_ack1",   {31'd0, ack1},   32'd1);
      chk("oor_err",    {31'd0, err},    32'd1);
      chk("oor_w_en",   {31'd0, w_en},   32'd0);
      chk("oor_chosen", {26'd0, chosen}, 32'd0);
      req1 = 1'b0;
      tick();
      chk("oor_err_pulse", {31'd0, err}, 32'd0);
      for (int i = 0; i < NREG; i++) begin
         chk("oor_bank", {19'd0, bank[i]}, {19'd0, snap[i]});
      end
      $display("txn oor: req1 addr=7 rejected");

      // 5. Fairness: req0 streams, req1 joins after cycle 5.
      e_ack0 = 8'b0101_0101;
      e_ack1 = 8'b0010_0000;
      n = 0;
      raise_c = 0;
      req0 = 1'b1; addr0 = 3'd0; data0 = 13'h0100;
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk("fr_ack0", {31'd0, ack0}, {31'd0, e_ack0[c-1]});
         chk("fr_ack1", {31'd0, ack1}, {31'd0, e_ack1[c-1]});
         $display("txn fair %0d: ack0=%0d ack1=%0d", c, ack0, ack1);
         if (ack1 && req1) begin
            chk("fr_latency", (c - raise_c <= 2) ? 32'd1 : 32'd0, 32'd1);
            req1 = 1'b0;
         end
         if (ack0) begin
            n++;
            addr0 = AW'(n % NREG);
            data0 = DW'(13'h0100 + n);
         end
         if (c == 5) begin
            req1 = 1'b1; addr1 = 3'd5; data1 = 13'h0BEE;
            raise_c = c;
         end
      end
      req0 = 1'b0;
      tick();
      chk("fr_bank5", {19'd0, bank[5]}, 32'h0BEE);

      // 6. Reset during the WRITE cycle of addr 4.
      wr4_base = wr4_cnt;
      req0 = 1'b1; addr0 = 3'd4; data0 = 13'h0AAA;
      tick();
      chk("mr_w_en_before", {31'd0, w_en}, 32'd1);
      rst = 1'b0;
      #1;
      chk("mr_w_en",   {31'd0, w_en},   32'd0);
      chk("mr_ack0",   {31'd0, ack0},   32'd0);
      chk("mr_chosen", {26'd0, chosen}, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      exp_sel = 6'b010000;
      chk("mr_retry_ack0",   {31'd0, ack0},   32'd1);
      chk("mr_retry_chosen", {26'd0, chosen}, {26'd0, exp_sel});
      req0 = 1'b0;
      tick();
      chk("mr_bank4",  {19'd0, bank[4]}, 32'h0AAA);
      chk("mr_wr4_cnt", 32'(wr4_cnt - wr4_base), 32'd1);
      $display("txn midreset: req0 addr=4 retried");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
